// File: rtl/robot_pose_tracker_if.sv
// Command handshake and pose bus between the decision logic (master) and
// the pose engine (slave).
// Handshake: a command transfers on a rising edge where cmd_valid and
// cmd_ready are both 1. cmd_valid/cmd come from the master and do not
// depend on cmd_ready. cmd_ready comes only from engine state.
interface robot_pose_tracker_if #(
    parameter int POS_W = 6
);
    logic             cmd_valid;
    logic [1:0]       cmd;
    logic             cmd_ready;
    logic [POS_W-1:0] robot_row;
    logic [POS_W-1:0] robot_column;
    logic [1:0]       robot_orientation;
    logic             move_tick;
    logic             move_done;
    logic             blocked;
    logic             anomaly;
    logic             fsm_pending;  // debug view of the command FSM (1 = PENDING)

    modport master (
        output cmd_valid, cmd,
        input  cmd_ready, robot_row, robot_column, robot_orientation,
               move_tick, move_done, blocked, anomaly, fsm_pending
    );

    modport slave (
        input  cmd_valid, cmd,
        output cmd_ready, robot_row, robot_column, robot_orientation,
               move_tick, move_done, blocked, anomaly, fsm_pending
    );
endinterface

// File: rtl/robot_pose_tracker.sv
// Pose engine for the pipe-cleaning robot. It holds row, column and heading
// on a ROWS x COLS map. It accepts one command at a time and executes it on
// the next move tick of a free-running period counter.
module robot_pose_tracker #(
    parameter int         ROWS           = 10,
    parameter int         COLS           = 20,
    parameter int         POS_W          = 6,
    parameter int         TICKS_PER_MOVE = 200000000,
    parameter int         TICK_W         = 28,
    parameter int         START_ROW      = 1,
    parameter int         START_COL      = 1,
    parameter logic [1:0] START_ORIENT   = 2'b10
) (
    input  logic                  clock_50,
    input  logic                  reset_key,
    robot_pose_tracker_if.slave   bus
);
    typedef enum logic {IDLE = 1'b0, PENDING = 1'b1} state_t;

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_MOVE - 1);
    localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(1);
    localparam logic [POS_W-1:0]  POS_ONE   = POS_W'(1);
    localparam logic [POS_W-1:0]  ROW_MAX   = POS_W'(ROWS);
    localparam logic [POS_W-1:0]  COL_MAX   = POS_W'(COLS);

    localparam logic [1:0] ORI_N = 2'b00;
    localparam logic [1:0] ORI_S = 2'b01;
    localparam logic [1:0] ORI_E = 2'b10;
    localparam logic [1:0] ORI_W = 2'b11;

    localparam logic [1:0] CMD_HOLD  = 2'b00;
    localparam logic [1:0] CMD_ADV   = 2'b01;
    localparam logic [1:0] CMD_LEFT  = 2'b10;
    localparam logic [1:0] CMD_RIGHT = 2'b11;

    state_t            state_q, state_d;
    logic [1:0]        cmd_q, cmd_d;
    logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
    logic [POS_W-1:0]  row_q, row_d;
    logic [POS_W-1:0]  col_q, col_d;
    logic [1:0]        orient_q, orient_d;
    logic              done_q, done_d;
    logic              blocked_q, blocked_d;
    logic              anomaly_q, anomaly_d;
    logic              tick;

    // Period counter: free-runs and wraps after the tick count.
    always_comb begin
        tick       = (tick_cnt_q == TICK_LAST);
        tick_cnt_d = tick ? '0 : tick_cnt_q + TICK_ONE;
    end

    // Command FSM and pose update. Boundary checks happen before any
    // arithmetic, so row and column never wrap.
    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        row_d     = row_q;
        col_d     = col_q;
        orient_d  = orient_q;
        done_d    = 1'b0;
        blocked_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    cmd_d   = bus.cmd;
                    state_d = PENDING;
                end
            end
            PENDING: begin
                if (tick) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    unique case (cmd_q)
                        CMD_HOLD: ;
                        CMD_LEFT: begin
                            unique case (orient_q)
                                ORI_N: orient_d = ORI_W;
                                ORI_W: orient_d = ORI_S;
                                ORI_S: orient_d = ORI_E;
                                ORI_E: orient_d = ORI_N;
                            endcase
                        end
                        CMD_RIGHT: begin
                            unique case (orient_q)
                                ORI_N: orient_d = ORI_E;
                                ORI_E: orient_d = ORI_S;
                                ORI_S: orient_d = ORI_W;
                                ORI_W: orient_d = ORI_N;
                            endcase
                        end
                        CMD_ADV: begin
                            unique case (orient_q)
                                ORI_N: if (row_q <= POS_ONE) blocked_d = 1'b1;
                                       else row_d = row_q - POS_ONE;
                                ORI_S: if (row_q >= ROW_MAX) blocked_d = 1'b1;
                                       else row_d = row_q + POS_ONE;
                                ORI_E: if (col_q >= COL_MAX) blocked_d = 1'b1;
                                       else col_d = col_q + POS_ONE;
                                ORI_W: if (col_q <= POS_ONE) blocked_d = 1'b1;
                                       else col_d = col_q - POS_ONE;
                            endcase
                        end
                    endcase
                end
            end
        endcase
    end

    // Sticky flag for a pose outside the map. Only illegal start values can reach it.
    always_comb begin
        anomaly_d = anomaly_q | (row_q < POS_ONE) | (row_q > ROW_MAX)
                              | (col_q < POS_ONE) | (col_q > COL_MAX);
    end

    // State registers. Reset discards any pending command.
    always_ff @(posedge clock_50) begin
        if (reset_key) begin
            state_q    <= IDLE;
            cmd_q      <= CMD_HOLD;
            tick_cnt_q <= '0;
            row_q      <= POS_W'(START_ROW);
            col_q      <= POS_W'(START_COL);
            orient_q   <= START_ORIENT;
            done_q     <= 1'b0;
            blocked_q  <= 1'b0;
            anomaly_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            tick_cnt_q <= tick_cnt_d;
            row_q      <= row_d;
            col_q      <= col_d;
            orient_q   <= orient_d;
            done_q     <= done_d;
            blocked_q  <= blocked_d;
            anomaly_q  <= anomaly_d;
        end
    end

    assign bus.cmd_ready         = (state_q == IDLE);
    assign bus.fsm_pending       = (state_q == PENDING);
    assign bus.robot_row         = row_q;
    assign bus.robot_column      = col_q;
    assign bus.robot_orientation = orient_q;
    assign bus.move_tick         = tick;
    assign bus.move_done         = done_q;
    assign bus.blocked           = blocked_q;
    assign bus.anomaly           = anomaly_q;
endmodule

// File: tb/tb_robot_pose_tracker.sv
// Bench for robot_pose_tracker with a short move period. A compass-angle
// reference model predicts pose, blocked and execution cycle per command.
module tb_robot_pose_tracker;
  localparam int ROWS  = 10;
  localparam int COLS  = 20;
  localparam int POS_W = 6;
  localparam int TPM   = 4;
  localparam int TW    = 3;
  localparam int PW    = 2 * POS_W + 2;

  // clock / reset
  logic clock_50 = 1'b0;
  logic reset_key = 1'b0;
  always #5 clock_50 = ~clock_50;

  robot_pose_tracker_if #(.POS_W(POS_W)) bus ();
  robot_pose_tracker_if #(.POS_W(POS_W)) abus ();

  robot_pose_tracker #(
    .ROWS(ROWS), .COLS(COLS), .POS_W(POS_W), .TICKS_PER_MOVE(TPM), .TICK_W(TW),
    .START_ROW(1), .START_COL(1), .START_ORIENT(2'b10)
  ) dut (
    .clock_50(clock_50), .reset_key(reset_key), .bus(bus)
  );

  robot_pose_tracker #(
    .ROWS(ROWS), .COLS(COLS), .POS_W(POS_W), .TICKS_PER_MOVE(TPM), .TICK_W(TW),
    .START_ROW(0), .START_COL(1), .START_ORIENT(2'b10)
  ) dut_anom (
    .clock_50(clock_50), .reset_key(reset_key), .bus(abus)
  );

  int errors = 0;
  int checks = 0;
  int since_rst = 0;
  logic [PW-1:0] exp_q[$];

  // reference pose
  int m_row, m_col;
  logic [1:0] m_or;

  // clock edges since the last reset edge; the period tick is where this is 3 mod 4
  always @(posedge clock_50) begin
    if (reset_key) since_rst <= 0;
    else since_rst <= since_rst + 1;
  end

  // heading as compass angle: 0 north, 1 east, 2 south, 3 west
  function automatic int ang(input logic [1:0] o);
    case (o)
      2'b00:   return 0;
      2'b10:   return 1;
      2'b01:   return 2;
      default: return 3;
    endcase
  endfunction

  function automatic logic [1:0] enc(input int a);
    case (a)
      0:       return 2'b00;
      1:       return 2'b10;
      2:       return 2'b01;
      default: return 2'b11;
    endcase
  endfunction

  task automatic model_apply(input logic [1:0] c, output logic blk);
    int a, nr, nc;
    blk = 1'b0;
    a = ang(m_or);
    case (c)
      2'b10: m_or = enc((a + 3) % 4);
      2'b11: m_or = enc((a + 1) % 4);
      2'b01: begin
        nr = m_row + ((a == 2) ? 1 : 0) - ((a == 0) ? 1 : 0);
        nc = m_col + ((a == 1) ? 1 : 0) - ((a == 3) ? 1 : 0);
        if (nr < 1 || nr > ROWS || nc < 1 || nc > COLS) blk = 1'b1;
        else begin
          m_row = nr;
          m_col = nc;
        end
      end
      default: ;
    endcase
  endtask

  function automatic logic [PW-1:0] model_pose();
    return {POS_W'(m_row), POS_W'(m_col), m_or};
  endfunction

  // driver tasks
  task automatic step();
    @(posedge clock_50);
    #1;
  endtask

  task automatic do_reset();
    bus.cmd_valid = 1'b0;
    reset_key = 1'b1;
    step();
    reset_key = 1'b0;
    m_row = 1;
    m_col = 1;
    m_or = 2'b10;
    exp_q.delete();
  endtask

  // Offer one command, then check pending behaviour, latency, pose and flags.
  task automatic issue_cmd(input logic [1:0] c);
    int n, acc, tgt;
    logic blk;
    logic [PW-1:0] exp_pose;
    n = 0;
    while (bus.cmd_ready !== 1'b1 && n < 20) begin step(); n++; end
    checks++;
    if (bus.cmd_ready !== 1'b1) begin
      errors++; $display("FAIL ready_wait: cmd_ready=%b required 1", bus.cmd_ready);
    end
    bus.cmd_valid = 1'b1;
    bus.cmd = c;
    acc = since_rst;
    model_apply(c, blk);
    exp_q.push_back(model_pose());
    step();
    bus.cmd_valid = 1'b0;
    tgt = acc + 1;
    while (tgt % TPM != TPM - 1) tgt++;
    n = 0;
    while (bus.move_done !== 1'b1 && n < 3 * TPM) begin
      checks++;
      if (bus.cmd_ready !== 1'b0 || bus.fsm_pending !== 1'b1) begin
        errors++; $display("FAIL pending_ready: cmd_ready=%b pending=%b required 0/1", bus.cmd_ready, bus.fsm_pending);
      end
      step(); n++;
    end
    checks++;
    if (bus.move_done !== 1'b1) begin
      errors++; $display("FAIL done_timeout: move_done=%b required 1 cmd=%b", bus.move_done, c);
    end
    checks++;
    if (since_rst !== tgt + 1) begin
      errors++; $display("FAIL done_latency: done at cycle %0d required %0d", since_rst, tgt + 1);
    end
    exp_pose = exp_q.pop_front();
    checks++;
    if ({bus.robot_row, bus.robot_column, bus.robot_orientation} !== exp_pose) begin
      errors++; $display("FAIL pose cmd=%b: got r=%0d c=%0d o=%b required %h", c,
        bus.robot_row, bus.robot_column, bus.robot_orientation, exp_pose);
    end
    checks++;
    if (bus.blocked !== blk || bus.cmd_ready !== 1'b1) begin
      errors++; $display("FAIL blocked_ready cmd=%b: blocked=%b ready=%b required %b/1", c, bus.blocked, bus.cmd_ready, blk);
    end
    step();
    checks++;
    if (bus.move_done !== 1'b0 || bus.blocked !== 1'b0) begin
      errors++; $display("FAIL pulse_width: move_done=%b blocked=%b required 0/0", bus.move_done, bus.blocked);
    end
  endtask

  // tests
  task automatic test_reset();
    do_reset();
    checks++;
    if ({bus.robot_row, bus.robot_column, bus.robot_orientation} !== model_pose()) begin
      errors++; $display("FAIL reset_pose: r=%0d c=%0d o=%b required 1 1 10", bus.robot_row, bus.robot_column, bus.robot_orientation);
    end
    checks++;
    if (bus.cmd_ready !== 1'b1 || bus.anomaly !== 1'b0 || bus.move_done !== 1'b0 || bus.blocked !== 1'b0) begin
      errors++; $display("FAIL reset_flags: ready=%b anomaly=%b done=%b blocked=%b required 1 0 0 0",
        bus.cmd_ready, bus.anomaly, bus.move_done, bus.blocked);
    end
    for (int i = 0; i < 3 * TPM; i++) begin
      checks++;
      if (bus.move_tick !== ((since_rst % TPM) == TPM - 1)) begin
        errors++; $display("FAIL move_tick cycle %0d: got %b", since_rst, bus.move_tick);
      end
      step();
    end
  endtask

  task automatic test_advance_east();
    for (int i = 0; i < 20; i++) issue_cmd(2'b01);
  endtask

  task automatic test_turns();
    for (int i = 0; i < 4; i++) issue_cmd(2'b11);
    for (int i = 0; i < 4; i++) issue_cmd(2'b10);
    for (int i = 0; i < 3; i++) issue_cmd(2'($urandom_range(0, 3)) & 2'b10 | 2'($urandom_range(0, 1)));
    issue_cmd(2'b00);
  endtask

  task automatic test_tick_accept();
    int n, acc;
    logic blk;
    logic [PW-1:0] exp_pose;
    n = 0;
    while (!(bus.move_tick === 1'b1 && bus.cmd_ready === 1'b1) && n < 20) begin step(); n++; end
    checks++;
    if (bus.move_tick !== 1'b1) begin
      errors++; $display("FAIL tick_wait: move_tick=%b required 1", bus.move_tick);
    end
    bus.cmd_valid = 1'b1;
    bus.cmd = 2'b11;
    acc = since_rst;
    model_apply(2'b11, blk);
    exp_pose = model_pose();
    step();
    bus.cmd = 2'b01;  // second offer while pending must be ignored
    n = 0;
    while (bus.move_done !== 1'b1 && n < 3 * TPM) begin
      checks++;
      if (bus.cmd_ready !== 1'b0) begin
        errors++; $display("FAIL tick_pending_ready: cmd_ready=%b required 0", bus.cmd_ready);
      end
      step(); n++;
    end
    bus.cmd_valid = 1'b0;
    checks++;
    if (since_rst !== acc + TPM + 1) begin
      errors++; $display("FAIL tick_latency: done at %0d required %0d", since_rst, acc + TPM + 1);
    end
    checks++;
    if ({bus.robot_row, bus.robot_column, bus.robot_orientation} !== exp_pose) begin
      errors++; $display("FAIL tick_pose: got o=%b c=%0d required %h", bus.robot_orientation, bus.robot_column, exp_pose);
    end
    for (int i = 0; i < 3 * TPM; i++) begin
      step();
      checks++;
      if (bus.move_done !== 1'b0 || {bus.robot_row, bus.robot_column, bus.robot_orientation} !== exp_pose) begin
        errors++; $display("FAIL second_offer: done=%b r=%0d c=%0d required no execution", bus.move_done, bus.robot_row, bus.robot_column);
      end
    end
  endtask

  task automatic test_reset_pending();
    int n;
    n = 0;
    while (bus.cmd_ready !== 1'b1 && n < 20) begin step(); n++; end
    bus.cmd_valid = 1'b1;
    bus.cmd = 2'b01;
    step();
    bus.cmd_valid = 1'b0;
    checks++;
    if (bus.cmd_ready !== 1'b0) begin
      errors++; $display("FAIL rp_accept: cmd_ready=%b required 0", bus.cmd_ready);
    end
    do_reset();
    checks++;
    if ({bus.robot_row, bus.robot_column, bus.robot_orientation} !== model_pose() || bus.cmd_ready !== 1'b1) begin
      errors++; $display("FAIL rp_state: r=%0d c=%0d o=%b ready=%b required start/1",
        bus.robot_row, bus.robot_column, bus.robot_orientation, bus.cmd_ready);
    end
    for (int i = 0; i < 3 * TPM; i++) begin
      checks++;
      if (bus.move_done !== 1'b0 || {bus.robot_row, bus.robot_column, bus.robot_orientation} !== model_pose()) begin
        errors++; $display("FAIL rp_discard: done=%b r=%0d required no execution", bus.move_done, bus.robot_row);
      end
      step();
    end
  endtask

  task automatic test_north_south();
    issue_cmd(2'b10);
    issue_cmd(2'b01);
    issue_cmd(2'b11);
    issue_cmd(2'b11);
    for (int i = 0; i < 10; i++) issue_cmd(2'b01);
  endtask

  task automatic test_anomaly();
    do_reset();
    checks++;
    if (abus.anomaly !== 1'b0 || abus.robot_row !== '0) begin
      errors++; $display("FAIL anom_reset: anomaly=%b row=%0d required 0/0", abus.anomaly, abus.robot_row);
    end
    for (int i = 0; i < 2 * TPM; i++) begin
      step();
      checks++;
      if (abus.anomaly !== 1'b1 || bus.anomaly !== 1'b0) begin
        errors++; $display("FAIL anom_sticky cycle %0d: anomaly=%b main=%b required 1/0", since_rst, abus.anomaly, bus.anomaly);
      end
    end
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd = 2'b00;
    abus.cmd_valid = 1'b0;
    abus.cmd = 2'b00;
    test_reset();
    test_advance_east();
    test_turns();
    test_tick_accept();
    test_reset_pending();
    test_north_south();
    test_anomaly();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/robot_pose_tracker.md
Name: robot_pose_tracker

Overview:
Parametrised pose engine for the pipe-cleaning robot. It holds the robot's row, column and orientation on a ROWS x COLS map and accepts one motion command at a time through a valid/ready handshake. Each accepted command executes on the next move tick of an internal period counter. It sits inside world between the decision logic and the map/sensor logic, and replaces the fixed 10x20, 4 s hard-coded pose update.

Parameters:
ROWS, 10, map rows (legal rows 1..ROWS; row 1 is the north edge)
COLS, 20, map columns (legal columns 1..COLS; column 1 is the west edge)
POS_W, 6, width of robot_row and robot_column; must hold max(ROWS, COLS)
TICKS_PER_MOVE, 200000000, clock_50 cycles per move period (4 s at 50 MHz); must be >= 2
TICK_W, 28, width of the period counter; must hold TICKS_PER_MOVE-1
START_ROW, 1, row loaded on reset
START_COL, 1, column loaded on reset
START_ORIENT, 2'b10, orientation loaded on reset (east)

Ports:
clock_50  in  1  system clock, 50 MHz; all state changes on the rising edge
reset_key  in  1  synchronous, active-high reset
cmd_valid  in  1  command offered
cmd  in  2  00 hold, 01 advance, 10 turn left, 11 turn right
cmd_ready  out  1  engine can accept a command
robot_row  out  POS_W  current row
robot_column  out  POS_W  current column
robot_orientation  out  2  00 north, 01 south, 10 east, 11 west
move_tick  out  1  one-cycle pulse at the end of each move period
move_done  out  1  one-cycle pulse when a command has executed
blocked  out  1  one-cycle pulse, coincident with move_done, when an advance was refused
anomaly  out  1  sticky flag: pose outside the legal map

Behaviour:
- Reset (reset_key=1 at an edge) loads the following values; reset mid-operation discards any pending command. Outputs after that edge:
  - period counter = 0
  - robot_row = START_ROW, robot_column = START_COL, robot_orientation = START_ORIENT
  - cmd_ready = 1
  - move_tick, move_done, blocked = 0
  - anomaly = 0
- Period counter:
  - Free-runs 0..TICKS_PER_MOVE-1 and wraps to 0.
  - move_tick = 1 combinationally while the counter equals TICKS_PER_MOVE-1.
  - The counter runs regardless of whether a command is pending.
- FSM, two states:
  - IDLE: cmd_ready = 1. On cmd_valid & cmd_ready at an edge, latch cmd and go to PENDING.
  - PENDING: cmd_ready = 0 and cmd_valid is ignored. In a cycle with move_tick = 1, execute the latched command at that edge and return to IDLE.
- Tick in the acceptance cycle: a command accepted in a cycle where move_tick = 1 does not execute on that tick. It waits for the following tick, so every command takes one full move period.
- Execution latency: the pose registers update at the tick edge. move_done (and blocked, if applicable) is high for exactly the next cycle, and cmd_ready returns to 1 in that same cycle.
- Command effects:
  - Hold: pose unchanged; move_done still pulses.
  - Turn left: N->W->S->E->N. Turn right: N->E->S->W->N. Position unchanged.
  - Advance: north row-1, south row+1, east column+1, west column-1.
  - If the advance target is row 0, row ROWS+1, column 0 or column COLS+1, the pose is unchanged and blocked pulses together with move_done. The robot never leaves the map through a command.
- Arithmetic: row and column are unsigned POS_W-bit values. The boundary test compares the current value against 1 and ROWS/COLS before any increment or decrement, so there is no reliance on wrap-around.
- Anomaly:
  - Evaluated every cycle on the registered pose: row < 1, row > ROWS, column < 1 or column > COLS sets anomaly at the next edge.
  - It stays set until reset. It is only reachable through illegal START_* parameters; pose behaviour continues unchanged while it is set.
- There is no back-pressure on outputs; the pose is always valid.

Test Plan:
- Reset with TICKS_PER_MOVE=4 and default map: after the reset edge, expect robot_row=1, robot_column=1, robot_orientation=east, cmd_ready=1, anomaly=0; move_tick pulses every 4 cycles.
- Advance east, 19 commands back-to-back: robot_column steps 2..20, one step per tick, each with a move_done pulse. A 20th advance keeps robot_column=20 with blocked=1 and move_done=1 in the same cycle.
- Turn right x4 from east: orientation sequence south, west, north, east. Turn left x4 from east: north, west, south, east. robot_row and robot_column unchanged throughout.
- Accept a command exactly in the move_tick cycle: it executes on the next tick, 4 cycles later. cmd_ready stays 0 throughout, and a second cmd_valid offered meanwhile is not consumed.
- Advance north from row 1: blocked pulses and row stays 1. Turn right twice, then advance 9 times to row 10; the next advance is blocked.
- Assert reset_key while PENDING: pose returns to START values, the pending command never executes (no move_done), cmd_ready=1 next cycle. Separately, instantiate START_ROW=0: anomaly=1 from the second cycle after reset and stays set.
